// File: rtl/hack_run_ctrl.sv
// Run controller for the Hack CPU: streams a program image into instruction ROM,
// then sequences the core through run, pause, single-step and halt.
module hack_run_ctrl #(
    parameter int ROM_AW   = 15,
    parameter int HALT_CNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [15:0]       cmd_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              cpu_clk_en,
    input  logic [15:0]       cpu_pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              err,
    output logic              load_done,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_HI = 3'd1,
        S_LOAD_LO = 3'd2,
        S_RUN     = 3'd3,
        S_STEP    = 3'd4,
        S_PAUSED  = 3'd5,
        S_HALTED  = 3'd6
    } state_e;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_STOP = 2'd3;
    localparam int CW = ROM_AW + 1;
    localparam int MW = $clog2(HALT_CNT + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       wcnt_q, wcnt_d;
    logic [CW-1:0]       len_q, len_d;
    logic [7:0]          hi_q, hi_d;
    logic                rom_we_q, rom_we_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [15:0]         rom_wdata_q, rom_wdata_d;
    logic                load_done_q, load_done_d;
    logic                err_q, err_d;
    logic [31:0]         cc_q, cc_d;
    logic [15:0]         h1_q, h1_d, h2_q, h2_d;
    logic [1:0]          hcnt_q, hcnt_d;
    logic [MW-1:0]       match_q, match_d;

    logic cmd_fire, byte_fire, len_ok, hist_full, pc_match;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign byte_fire = byte_valid && byte_ready;
    assign len_ok    = (cmd_len != 16'd0) && ({16'd0, cmd_len} <= (32'd1 << ROM_AW));
    assign hist_full = (hcnt_q == 2'd2);
    assign pc_match  = hist_full && (cpu_pc == h2_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            len_q       <= '0;
            hi_q        <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            cc_q        <= '0;
            h1_q        <= '0;
            h2_q        <= '0;
            hcnt_q      <= '0;
            match_q     <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
            cc_q        <= cc_d;
            h1_q        <= h1_d;
            h2_q        <= h2_d;
            hcnt_q      <= hcnt_d;
            match_q     <= match_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        len_d       = len_q;
        hi_d        = hi_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        load_done_d = 1'b0;
        err_d       = 1'b0;
        cc_d        = cc_q;
        h1_d        = h1_q;
        h2_d        = h2_q;
        hcnt_d      = hcnt_q;
        match_d     = match_q;

        // Every cycle the core is enabled counts, including the one that accepts STOP.
        if (state_q == S_RUN || state_q == S_STEP)
            cc_d = cc_q + 32'd1;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            if (len_ok) begin
                                wcnt_d  = '0;
                                len_d   = CW'(cmd_len);
                                state_d = S_LOAD_HI;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_RUN: begin
                            cc_d    = '0;
                            hcnt_d  = '0;
                            match_d = '0;
                            state_d = S_RUN;
                        end
                        OP_STEP: begin
                            cc_d    = '0;
                            state_d = S_STEP;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD_HI: begin
                if (byte_fire) begin
                    hi_d    = byte_data;
                    state_d = S_LOAD_LO;
                end
            end
            S_LOAD_LO: begin
                if (byte_fire) begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = wcnt_q[ROM_AW-1:0];
                    rom_wdata_d = {hi_q, byte_data};
                    wcnt_d      = wcnt_q + CW'(1);
                    if (wcnt_q + CW'(1) == len_q) begin
                        load_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_LOAD_HI;
                    end
                end
            end
            S_RUN: begin
                h2_d    = h1_q;
                h1_d    = cpu_pc;
                hcnt_d  = hist_full ? 2'd2 : hcnt_q + 2'd1;
                match_d = pc_match ? match_q + MW'(1) : '0;
                // STOP takes priority over a halt detected in the same cycle.
                if (cmd_fire) begin
                    if (cmd_op == OP_STOP) state_d = S_PAUSED;
                    else                   err_d   = 1'b1;
                end else if (pc_match && (match_q + MW'(1) == MW'(HALT_CNT))) begin
                    state_d = S_HALTED;
                end
            end
            S_STEP: state_d = S_PAUSED;
            S_PAUSED, S_HALTED: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_RUN: begin
                            hcnt_d  = '0;
                            match_d = '0;
                            state_d = S_RUN;
                        end
                        OP_STEP: state_d = S_STEP;
                        OP_STOP: state_d = S_IDLE;
                        default: err_d   = 1'b1;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == S_IDLE) || (state_q == S_RUN) ||
                         (state_q == S_PAUSED) || (state_q == S_HALTED);
    assign byte_ready  = (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO);
    assign cpu_reset   = (state_q == S_IDLE) || byte_ready;
    assign cpu_clk_en  = (state_q == S_RUN) || (state_q == S_STEP);
    assign halted      = (state_q == S_HALTED);
    assign state       = state_q;
    assign rom_we      = rom_we_q;
    assign rom_addr    = rom_addr_q;
    assign rom_wdata   = rom_wdata_q;
    assign load_done   = load_done_q;
    assign err         = err_q;
    assign cycle_count = cc_q;

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Scoreboard bench for hack_run_ctrl with a small CPU model driving cpu_pc.
module tb_hack_run_ctrl;
    localparam int ROM_AW   = 15;
    localparam int HALT_CNT = 4;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_STOP = 2'd3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [15:0]       cmd_len = 16'd0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              rom_we;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic              cpu_clk_en;
    logic [15:0]       cpu_pc;
    logic [2:0]        state;
    logic              halted;
    logic              err;
    logic              load_done;
    logic [31:0]       cycle_count;

    always #5 clk = ~clk;

    hack_run_ctrl #(.ROM_AW(ROM_AW), .HALT_CNT(HALT_CNT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_reset(cpu_reset), .cpu_clk_en(cpu_clk_en), .cpu_pc(cpu_pc),
        .state(state), .halted(halted), .err(err), .load_done(load_done),
        .cycle_count(cycle_count)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [ROM_AW-1:0] addr;
        logic [15:0]       data;
        logic              last;
    } wr_t;
    wr_t         wr_q[$];
    wr_t         mon_e;
    int          err_exp = 0;
    logic [15:0] img[$];

    // CPU model: program counter trace indexed by executed instructions.
    logic [15:0] prog[0:127];
    logic [6:0]  pc_idx;
    always @(posedge clk or posedge reset) begin
        if (reset)           pc_idx <= '0;
        else if (cpu_reset)  pc_idx <= '0;
        else if (cpu_clk_en) pc_idx <= pc_idx + 7'd1;
    end
    assign cpu_pc = prog[pc_idx];

    // Monitor: every ROM write and every err pulse must match a pushed expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (rom_we) begin
                tests++;
                if (wr_q.size() == 0) begin
                    fails++;
                    $display("FAIL rom_write: unexpected write addr=%0h data=%04h", rom_addr, rom_wdata);
                end else begin
                    mon_e = wr_q.pop_front();
                    if (rom_addr !== mon_e.addr || rom_wdata !== mon_e.data || load_done !== mon_e.last) begin
                        fails++;
                        $display("FAIL rom_write: got addr=%0h data=%04h done=%0b expected addr=%0h data=%04h done=%0b",
                                 rom_addr, rom_wdata, load_done, mon_e.addr, mon_e.data, mon_e.last);
                    end
                end
            end else if (load_done) begin
                tests++;
                fails++;
                $display("FAIL load_done: pulse without rom_we");
            end
            if (err) begin
                tests++;
                if (err_exp == 0) begin
                    fails++;
                    $display("FAIL err_pulse: got err=1 expected no error pending");
                end else begin
                    err_exp--;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] len);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            tests++; fails++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1");
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        while (!byte_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!byte_ready) begin
            tests++; fails++;
            $display("FAIL byte_ready_timeout: got 0 expected 1");
        end
        byte_valid = 1'b1; byte_data = b;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic do_load();
        wr_t w;
        send_cmd(OP_LOAD, 16'(img.size()));
        for (int i = 0; i < img.size(); i++) begin
            w.addr = ROM_AW'(i);
            w.data = img[i];
            w.last = (i == img.size() - 1);
            wr_q.push_back(w);
            send_byte(img[i][15:8], $urandom_range(0, 2));
            send_byte(img[i][7:0], $urandom_range(0, 2));
        end
        check("load_end_state", state, 0);
    endtask

    // Expected cycle_count at halt: first RUN cycle k whose pc equals the pc two
    // cycles earlier for HALT_CNT cycles in a row; the core has executed k+1 cycles.
    function automatic int halt_cycle();
        int m = 0;
        for (int k = 2; k < 128; k++) begin
            if (prog[k] == prog[k-2]) m++;
            else m = 0;
            if (m == HALT_CNT) return k + 1;
        end
        return -1;
    endfunction

    task automatic run_to_halt(input int exp_cc);
        int n = 0;
        send_cmd(OP_RUN, 16'd0);
        check("run_clk_en", cpu_clk_en, 1);
        check("run_cpu_reset", cpu_reset, 0);
        while (state != 3'd6 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("halt_state", state, 6);
        check("halt_halted", halted, 1);
        check("halt_clk_en", cpu_clk_en, 0);
        check("halt_cycle_count", cycle_count, exp_cc);
        repeat (3) begin @(posedge clk); #1; end
        check("halt_cc_frozen", cycle_count, exp_cc);
        send_cmd(OP_STOP, 16'd0);
        check("halt_stop_idle", state, 0);
        check("halt_stop_cpu_reset", cpu_reset, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, len, exp_cc;
        wr_t w;
        for (int i = 0; i < 128; i++) prog[i] = 16'(i);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_state", state, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_clk_en", cpu_clk_en, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_halted", halted, 0);

        err_exp++; send_cmd(OP_LOAD, 16'd0);
        check("err_len0_state", state, 0);
        err_exp++; send_cmd(OP_LOAD, 16'((1 << ROM_AW) + 1));
        check("err_lenbig_state", state, 0);
        err_exp++; send_cmd(OP_STOP, 16'd0);
        check("err_stop_idle_state", state, 0);

        img = '{16'h1234, 16'hABCD};
        do_load();
        for (int t = 0; t < 3; t++) begin
            img.delete();
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) img.push_back(16'($urandom));
            do_load();
        end

        for (int i = 0; i < 128; i++) prog[i] = (i < 6) ? 16'(i) : ((i % 2 == 0) ? 16'd4 : 16'd5);
        run_to_halt(10);
        for (int t = 0; t < 4; t++) begin
            p = $urandom_range(0, 6);
            len = $urandom_range(1, 2);
            for (int i = 0; i < 128; i++)
                prog[i] = (i < p) ? 16'($urandom_range(0, 7)) : 16'(20 + ((i - p) % len));
            run_to_halt(halt_cycle());
        end

        for (int i = 0; i < 128; i++) prog[i] = 16'(i);
        send_cmd(OP_RUN, 16'd0);
        repeat (9) begin @(posedge clk); #1; end
        send_cmd(OP_STOP, 16'd0);
        check("pause_state", state, 5);
        check("pause_cc", cycle_count, 10);
        check("pause_cpu_reset", cpu_reset, 0);
        exp_cc = 10;
        for (int s = 0; s < 2; s++) begin
            send_cmd(OP_STEP, 16'd0);
            check("step_state", state, 4);
            check("step_clk_en", cpu_clk_en, 1);
            @(posedge clk); #1;
            exp_cc++;
            check("step_back_paused", state, 5);
            check("step_cc", cycle_count, exp_cc);
            check("step_cpu_reset", cpu_reset, 0);
        end
        send_cmd(OP_RUN, 16'd0);
        err_exp++; send_cmd(OP_LOAD, 16'd1);
        check("err_load_in_run_state", state, 3);
        repeat (4) begin @(posedge clk); #1; end
        send_cmd(OP_STOP, 16'd0);
        check("resume_cc", cycle_count, exp_cc + 6);
        send_cmd(OP_STOP, 16'd0);
        check("stop_to_idle", state, 0);
        check("stop_cpu_reset", cpu_reset, 1);

        send_cmd(OP_LOAD, 16'd5);
        for (int i = 0; i < 3; i++) begin
            w.addr = ROM_AW'(i);
            w.data = 16'($urandom);
            w.last = 1'b0;
            wr_q.push_back(w);
            send_byte(w.data[15:8], $urandom_range(0, 1));
            send_byte(w.data[7:0], 0);
        end
        send_byte(8'h5A, 0);
        check("midload_state", state, 2);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midload_rst_state", state, 0);
        check("midload_rst_cpu_reset", cpu_reset, 1);
        check("midload_rst_rom_we", rom_we, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        img = '{16'hC0DE};
        do_load();

        repeat (3) begin @(posedge clk); #1; end
        check("wr_queue_empty", wr_q.size(), 0);
        check("err_all_seen", err_exp, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
